qmult_seq: RTL and testbench
============================

# qmult_seq

Sequential sign-magnitude fixed-point multiplier: the multiply-side counterpart of the iterative fixed-point divider in the accelerator datapath. It uses the same N-bit, Q-fractional-bit sign-magnitude number format and the same start/enable/complete/overflow handshake, so control logic can drive either unit interchangeably. It computes one partial product per enabled cycle by shift-and-add, trading latency for area in the scaling and normalisation stages.

## Interface
- Q, default FXP_R (8): fractional bits.
- N, default FXP_N (16): total width, MSB is the sign bit; magnitude is N-1 bits.
- i_clk, input, 1: clock, rising edge.
- i_reset, input, 1: reset. One clock; reset is asynchronous and active-high.
- i_multiplicand, input, N: sign-magnitude operand A.
- i_multiplier, input, N: sign-magnitude operand B.
- i_start, input, 1: request a multiply. Sampled only when idle and enabled.
- i_enable, input, 1: global advance. Low freezes all state.
- o_product, output, N: sign-magnitude result, registered.
- o_complete, output, 1: level; high = idle, result valid.
- o_overflow, output, 1: result magnitude exceeded N-1 bits. Valid while o_complete is high.

## Operation
- States are IDLE (o_complete=1) and BUSY (o_complete=0).
- Reset values: o_complete=1, o_overflow=0, o_product=0. All internal registers are 0.
- Accept: IDLE & i_enable & i_start. Latch magA=A[N-2:0] into a 2N-2 bit shift register (mcand), magB=B[N-2:0] (mplier), clear the 2N-2 bit accumulator, set sign=A[N-1]^B[N-1], clear o_overflow, load count=N-2, and enter BUSY.
- In BUSY, each enabled cycle: if mplier[0], acc <= acc + mcand. Then mcand <<= 1, mplier >>= 1, count -= 1.
- Last step (count==0): the final accumulate is included, o_product <= {sign, sum[N-2+Q:Q]} and o_overflow <= |sum[2N-3:N-1+Q]. Return to IDLE. Here sum is the accumulator value including the final add.
- Fractional bits sum[Q-1:0] are truncated, with no rounding.
- The sign is always the XOR of the input signs, even for a zero magnitude (negative zero is legal, matching the divider).
- i_start while BUSY is ignored. Operands are not sampled after accept.
- o_product and o_overflow hold their last values until the next completion. They are not cleared on accept, except o_overflow.

## Timing
- Latency: o_complete falls on the accept edge and rises on the (N-1)th enabled BUSY edge after it. That is 15 enabled cycles for N=16.
- i_enable low in any state: no state change, including the count. The latency extends by the number of stalled cycles.
- Back-to-back: i_start high in the first cycle o_complete is high is accepted. The maximum throughput is one result per N cycles.
- i_reset asserted mid-operation: immediate return to the reset values, and the in-flight result is discarded.
- The accept and completion edges never coincide, because a start is only sampled in IDLE.

## Structure
- FXP_N and FXP_R live in the shared fixed-point package fxp_pkg, which is also used by the divider. Any format typedef also belongs there.
- The count register is $clog2(N) bits wide.
- The block is a single module with no sub-modules. An explicit two-state enum is local to the module.

## Test plan
- 0x0180 (1.5) × 0x0200 (2.0) -> after 15 cycles, o_product=0x0300 and o_overflow=0.
- 0x8180 × 0x0200 -> o_product=0x8300. Then 0x8180 × 0x8200 -> o_product=0x0300.
- 0x4000 (64) × 0x0400 (4) -> o_overflow=1 and o_product=0x0000.
- 0x0001 × 0x0001 -> truncation gives o_product=0x0000 and o_overflow=0. 0x8001 × 0x0001 -> o_product=0x8000.
- Stall: hold i_enable low for 5 cycles mid-operation -> completion occurs at 20 cycles with an unchanged result. An i_start pulse while BUSY is ignored.
- Assert i_reset at step 7 -> o_complete=1, o_product=0, o_overflow=0 asynchronously. A new start then completes correctly.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point format, common to the multiplier and the divider.
package fxp_pkg;

  localparam int FXP_N = 16;
  localparam int FXP_R = 8;

  typedef logic [FXP_N-1:0] fxp_t;

endpackage

// File: rtl/qmult_seq.sv
// Iterative sign-magnitude fixed-point multiplier, one shift-and-add partial
// product per enabled cycle; handshake matches the iterative divider.
module qmult_seq
  import fxp_pkg::*;
#(
  parameter int Q = FXP_R,
  parameter int N = FXP_N
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  input  logic         i_enable,
  output logic [N-1:0] o_product,
  output logic         o_complete,
  output logic         o_overflow
);

  localparam int PW = 2*N-2;
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  mcand, mcand_nxt;
  logic [PW-1:0]  acc, acc_nxt;
  logic [PW-1:0]  sum;
  logic [N-2:0]   mplier, mplier_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic           sign, sign_nxt;
  logic [N-1:0]   product_nxt;
  logic           overflow_nxt;

  // Accumulator value including this step's partial product.
  assign sum = acc + (mplier[0] ? mcand : '0);

  assign o_complete = (state == IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      count      <= '0;
      sign       <= 1'b0;
      o_product  <= '0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      mcand      <= mcand_nxt;
      acc        <= acc_nxt;
      mplier     <= mplier_nxt;
      count      <= count_nxt;
      sign       <= sign_nxt;
      o_product  <= product_nxt;
      o_overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    acc_nxt      = acc;
    mplier_nxt   = mplier;
    count_nxt    = count;
    sign_nxt     = sign;
    product_nxt  = o_product;
    overflow_nxt = o_overflow;
    if (i_enable) begin
      case (state)
        IDLE: begin
          if (i_start) begin
            mcand_nxt    = {{(PW-N+1){1'b0}}, i_multiplicand[N-2:0]};
            mplier_nxt   = i_multiplier[N-2:0];
            acc_nxt      = '0;
            sign_nxt     = i_multiplicand[N-1] ^ i_multiplier[N-1];
            overflow_nxt = 1'b0;
            count_nxt    = CW'(N-2);
            state_nxt    = BUSY;
          end
        end
        BUSY: begin
          acc_nxt    = sum;
          mcand_nxt  = {mcand[PW-2:0], 1'b0};
          mplier_nxt = {1'b0, mplier[N-2:1]};
          count_nxt  = count - 1'b1;
          if (count == '0) begin
            // Drop the Q fractional bits; anything above the magnitude field is overflow.
            product_nxt  = {sign, sum[N-2+Q:Q]};
            overflow_nxt = |sum[PW-1:N-1+Q];
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_seq.sv
// Scoreboard bench for qmult_seq: expected results queued at start, checked at completion.
module tb_qmult_seq;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_multiplicand = '0;
  logic [15:0] i_multiplier = '0;
  logic        i_start = 1'b0;
  logic        i_enable = 1'b1;
  logic [15:0] o_product;
  logic        o_complete;
  logic        o_overflow;

  typedef struct packed {
    logic [15:0] p;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  qmult_seq dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_multiplicand(i_multiplicand),
    .i_multiplier(i_multiplier),
    .i_start(i_start),
    .i_enable(i_enable),
    .o_product(o_product),
    .o_complete(o_complete),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    logic [29:0] f;
    exp_t e;
    f = 30'(a[14:0]) * 30'(b[14:0]);
    e.p = {a[15] ^ b[15], f[22:8]};
    e.o = |f[29:23];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    i_multiplicand = a;
    i_multiplier   = b;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_start        = 1'b0;
    i_multiplicand = 16'($urandom);
    i_multiplier   = 16'($urandom);
  endtask

  task automatic wait_done(inout int cyc);
    while (o_complete !== 1'b1 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    if (o_complete !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge i_clk);
    total++; if (o_complete !== 1'b1) begin bad++; $display("FAIL reset_complete got=%b want=1", o_complete); end
    total++; if (o_product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h want=0000", o_product); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", o_overflow); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_basic;
    logic [15:0] ta [6] = '{16'h0180, 16'h8180, 16'h8180, 16'h4000, 16'h0001, 16'h8001};
    logic [15:0] tb [6] = '{16'h0200, 16'h0200, 16'h8200, 16'h0400, 16'h0001, 16'h0001};
    logic [15:0] tp [6] = '{16'h0300, 16'h8300, 16'h0300, 16'h0000, 16'h0000, 16'h8000};
    logic        to [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      int   cyc;
      exp_t e;
      sb.push_back('{p: tp[i], o: to[i]});
      do_start(ta[i], tb[i]);
      total++; if (o_complete !== 1'b0) begin bad++; $display("FAIL basic%0d_busy got=%b want=0", i, o_complete); end
      cyc = 0;
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 15) begin bad++; $display("FAIL basic%0d_latency got=%0d want=15", i, cyc); end
      total++; if (o_product !== e.p) begin bad++; $display("FAIL basic%0d_product got=%h want=%h", i, o_product, e.p); end
      total++; if (o_overflow !== e.o) begin bad++; $display("FAIL basic%0d_overflow got=%b want=%b", i, o_overflow, e.o); end
      repeat (2) @(negedge i_clk);
    end
  endtask

  task automatic test_stall;
    int   cyc;
    int   drops;
    exp_t e;
    sb.push_back(model(16'h0380, 16'h8140));
    do_start(16'h0380, 16'h8140);
    cyc = 0;
    drops = 0;
    repeat (5) begin @(negedge i_clk); cyc++; end
    i_enable = 1'b0;
    i_start = 1'b1;
    i_multiplicand = 16'h7fff;
    i_multiplier = 16'h7fff;
    repeat (5) begin
      @(negedge i_clk); cyc++;
      if (o_complete !== 1'b0) drops++;
    end
    total++; if (drops !== 0) begin bad++; $display("FAIL stall_frozen got=%0d want=0", drops); end
    i_enable = 1'b1;
    @(negedge i_clk); cyc++;
    i_start = 1'b0;
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 20) begin bad++; $display("FAIL stall_latency got=%0d want=20", cyc); end
    total++; if (o_product !== e.p) begin bad++; $display("FAIL stall_product got=%h want=%h", o_product, e.p); end
    total++; if (o_overflow !== e.o) begin bad++; $display("FAIL stall_overflow got=%b want=%b", o_overflow, e.o); end
    @(negedge i_clk);
    total++; if (o_complete !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got=%b want=1", o_complete); end
    i_enable = 1'b0;
    i_start = 1'b1;
    repeat (2) @(negedge i_clk);
    total++; if (o_complete !== 1'b1) begin bad++; $display("FAIL idle_disabled_start got=%b want=1", o_complete); end
    i_start = 1'b0;
    i_enable = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid;
    int   cyc;
    exp_t e;
    sb.push_back(model(16'h0555, 16'h0333));
    do_start(16'h0555, 16'h0333);
    repeat (6) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    total++; if (o_complete !== 1'b1) begin bad++; $display("FAIL rstmid_complete got=%b want=1", o_complete); end
    total++; if (o_product !== 16'h0000) begin bad++; $display("FAIL rstmid_product got=%h want=0000", o_product); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%b want=0", o_overflow); end
    sb.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    sb.push_back(model(16'h8240, 16'h0120));
    do_start(16'h8240, 16'h0120);
    cyc = 0;
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (cyc !== 15) begin bad++; $display("FAIL rstmid_latency got=%0d want=15", cyc); end
    total++; if (o_product !== e.p) begin bad++; $display("FAIL rstmid_result got=%h want=%h", o_product, e.p); end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      int          cyc;
      exp_t        e;
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) begin a = 16'h7fff; b = 16'h7fff; end
      if (i == 1) begin a = 16'h8000; b = 16'h0123; end
      sb.push_back(model(a, b));
      do_start(a, b);
      cyc = 0;
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 15) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=15", i, cyc); end
      total++; if (o_product !== e.p) begin bad++; $display("FAIL b2b%0d_product a=%h b=%h got=%h want=%h", i, a, b, o_product, e.p); end
      total++; if (o_overflow !== e.o) begin bad++; $display("FAIL b2b%0d_overflow got=%b want=%b", i, o_overflow, e.o); end
    end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
